// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage and the controller.
// State encoding and opcode field geometry live here so both blocks agree.
package instr_fetch_unit_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    // Opcode occupies the top OPC_W bits of the instruction word
    localparam int unsigned OPC_W = 6;

    // Width of the memory-wait counter (TIMEOUT legal range 1..255)
    localparam int unsigned TMO_CW = 8;

    // LSB position of the opcode field for a given instruction width
    function automatic int unsigned opc_lsb(input int unsigned iw);
        return iw - OPC_W;
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Loadable down-counter bounding how long a memory read may stay outstanding.
// o_expire_c is a combinational pulse while enabled with the count at zero.
module fetch_timeout_ctr
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned CW = TMO_CW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_en,
    output logic          o_expire_c
);

    logic [CW-1:0] r_cnt;

    // Load takes priority so a back-to-back read restarts the full window
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_expire_c = i_en && (r_cnt == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory, and holds the
// fetched word in IR with a valid flag until the controller acknowledges it.
// Optional one-entry prefetch buffer enabled by defining IFETCH_PREFETCH_EN.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned AW      = 8,
    parameter int unsigned IW      = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             g_clk,
    input  logic             g_clr,
    input  logic             fetch_req,
    input  logic             pc_load,
    input  logic [AW-1:0]    pc_load_val,
    input  logic             i_ack,
    output logic             mem_rd,
    output logic [AW-1:0]    mem_addr,
    input  logic             mem_ack,
    input  logic [IW-1:0]    mem_data,
    output logic [OPC_W-1:0] opcode,
    output logic [IW-7:0]    operand,
    output logic             i_odv,
    output logic [AW-1:0]    pc,
    output logic             busy,
    output logic             fetch_err
);

    localparam int unsigned     OPC_LSB  = opc_lsb(IW);
    localparam logic [TMO_CW-1:0] TMO_LOAD = TMO_CW'(TIMEOUT - 1);

    fetch_state_e  r_state,    w_nxt_state;
    logic [AW-1:0] r_pc,       w_nxt_pc;
    logic [IW-1:0] r_ir,       w_nxt_ir;
    logic          r_odv,      w_nxt_odv;
    logic          r_mem_rd,   w_nxt_mem_rd;
    logic [AW-1:0] r_mem_addr, w_nxt_mem_addr;
    logic          r_busy,     w_nxt_busy;
    logic          r_err,      w_nxt_err;
    logic [AW-1:0] r_pc_pend,  w_nxt_pc_pend;
    logic          r_discard,  w_nxt_discard;
    logic          w_ctr_load;
    logic          w_expire_c;

`ifdef IFETCH_PREFETCH_EN
    logic [IW-1:0] r_pb,       w_nxt_pb;
    logic          r_pb_vld,   w_nxt_pb_vld;
    logic          r_pf_halt,  w_nxt_pf_halt;
    logic          w_pf_done;
    logic          w_pf_good;

    // A read outstanding while in HOLD is a prefetch
    assign w_pf_done = r_mem_rd && (mem_ack || w_expire_c);
    assign w_pf_good = r_mem_rd && mem_ack && !r_discard && !pc_load;
`endif

    // Memory-wait window, running whenever a read strobe is out
    fetch_timeout_ctr #(
        .CW         (TMO_CW)
    ) u_tmo (
        .i_clk      (g_clk),
        .i_rst      (g_clr),
        .i_load     (w_ctr_load),
        .i_load_val (TMO_LOAD),
        .i_en       (r_mem_rd),
        .o_expire_c (w_expire_c)
    );

    // Next-state and next-output computation
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_pc       = r_pc;
        w_nxt_ir       = r_ir;
        w_nxt_odv      = r_odv;
        w_nxt_mem_rd   = r_mem_rd;
        w_nxt_mem_addr = r_mem_addr;
        w_nxt_err      = r_err;
        w_nxt_pc_pend  = r_pc_pend;
        w_nxt_discard  = r_discard;
        w_ctr_load     = 1'b0;
`ifdef IFETCH_PREFETCH_EN
        w_nxt_pb       = r_pb;
        w_nxt_pb_vld   = r_pb_vld;
        w_nxt_pf_halt  = r_pf_halt;
`endif

        case (r_state)
            ST_IDLE: begin
                // A simultaneous load redirects the fetch address
                if (pc_load) begin
                    w_nxt_pc = pc_load_val;
                end
                if (fetch_req) begin
                    w_nxt_err      = 1'b0;
                    w_nxt_state    = ST_REQ;
                    w_nxt_mem_rd   = 1'b1;
                    w_nxt_mem_addr = w_nxt_pc;
                    w_nxt_discard  = 1'b0;
                    w_ctr_load     = 1'b1;
                end
            end

            ST_REQ: begin
                // A branch arriving mid-read is parked until the read retires
                if (pc_load) begin
                    w_nxt_pc_pend = pc_load_val;
                    w_nxt_discard = 1'b1;
                end
                if (mem_ack || w_expire_c) begin
                    w_nxt_mem_rd  = 1'b0;
                    w_nxt_discard = 1'b0;
                    if (!mem_ack) begin
                        w_nxt_err = 1'b1;
                    end
                    if (pc_load || r_discard) begin
                        w_nxt_pc    = pc_load ? pc_load_val : r_pc_pend;
                        w_nxt_state = ST_IDLE;
                    end else if (mem_ack) begin
                        w_nxt_ir    = mem_data;
                        w_nxt_pc    = r_pc + AW'(1);
                        w_nxt_odv   = 1'b1;
                        w_nxt_state = ST_HOLD;
                    end else begin
                        w_nxt_state = ST_IDLE;
                    end
                end
            end

            ST_HOLD: begin
`ifdef IFETCH_PREFETCH_EN
                // Redirect flushes the buffer and poisons any in-flight prefetch
                if (pc_load) begin
                    w_nxt_pc     = pc_load_val;
                    w_nxt_pb_vld = 1'b0;
                    if (r_mem_rd) begin
                        w_nxt_discard = 1'b1;
                    end
                end
                if (w_pf_done) begin
                    w_nxt_mem_rd  = 1'b0;
                    w_nxt_discard = 1'b0;
                    if (!mem_ack) begin
                        w_nxt_err     = 1'b1;
                        w_nxt_pf_halt = 1'b1;
                    end
                end
                if (i_ack) begin
                    if (r_pb_vld && !pc_load) begin
                        w_nxt_ir     = r_pb;
                        w_nxt_pb_vld = 1'b0;
                    end else if (w_pf_good) begin
                        w_nxt_ir = mem_data;
                        w_nxt_pc = r_pc + AW'(1);
                    end else if (r_mem_rd && !w_pf_done) begin
                        w_nxt_odv     = 1'b0;
                        w_nxt_state   = ST_REQ;
                        w_nxt_pc_pend = w_nxt_pc;
                    end else begin
                        w_nxt_odv   = 1'b0;
                        w_nxt_state = ST_IDLE;
                    end
                end else if (w_pf_good) begin
                    w_nxt_pb     = mem_data;
                    w_nxt_pb_vld = 1'b1;
                    w_nxt_pc     = r_pc + AW'(1);
                end
`else
                if (pc_load) begin
                    w_nxt_pc = pc_load_val;
                end
                if (i_ack) begin
                    w_nxt_odv   = 1'b0;
                    w_nxt_state = ST_IDLE;
                end
`endif
            end

            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase

`ifdef IFETCH_PREFETCH_EN
        // Keep the buffer topped up while holding, unless a prefetch timed out
        if (w_nxt_state != ST_HOLD) begin
            w_nxt_pf_halt = 1'b0;
        end
        if ((w_nxt_state == ST_HOLD) && !w_nxt_mem_rd && !w_nxt_pb_vld &&
            !w_nxt_pf_halt && !pc_load) begin
            w_nxt_mem_rd   = 1'b1;
            w_nxt_mem_addr = w_nxt_pc;
            w_ctr_load     = 1'b1;
        end
`endif

        w_nxt_busy = (w_nxt_state != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_ir       <= '0;
            r_odv      <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_pc_pend  <= '0;
            r_discard  <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_pc       <= w_nxt_pc;
            r_ir       <= w_nxt_ir;
            r_odv      <= w_nxt_odv;
            r_mem_rd   <= w_nxt_mem_rd;
            r_mem_addr <= w_nxt_mem_addr;
            r_busy     <= w_nxt_busy;
            r_err      <= w_nxt_err;
            r_pc_pend  <= w_nxt_pc_pend;
            r_discard  <= w_nxt_discard;
        end
    end

`ifdef IFETCH_PREFETCH_EN
    // Prefetch buffer registers
    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            r_pb      <= '0;
            r_pb_vld  <= 1'b0;
            r_pf_halt <= 1'b0;
        end else begin
            r_pb      <= w_nxt_pb;
            r_pb_vld  <= w_nxt_pb_vld;
            r_pf_halt <= w_nxt_pf_halt;
        end
    end
`endif

    assign mem_rd    = r_mem_rd;
    assign mem_addr  = r_mem_addr;
    assign opcode    = r_ir[IW-1:OPC_LSB];
    assign operand   = r_ir[OPC_LSB-1:0];
    assign i_odv     = r_odv;
    assign pc        = r_pc;
    assign busy      = r_busy;
    assign fetch_err = r_err;

endmodule
